// File: rtl/rmii_rx_capture.sv
// RMII receive front end: preamble/SFD hunt, dibit-to-byte assembly,
// CRC32 check, frame length/status and a flat capture window.
//
// Ports:
//   clk, resn              50 MHz RMII reference clock, async active-low reset
//   rx_crs_dv, rx_d        RMII CRS_DV and RXD[1:0]
//   arm                    pulse that re-enables capture
//   byte_valid, byte_data  assembled byte stream, LSB dibit first
//   frame_done             end-of-frame pulse
//   frame_len, crc_ok      status of the last captured frame
//   overflow               last captured frame ran past the window
//   armed                  capture enabled
//   capture                window bytes, byte i at [8i+7:8i]
module rmii_rx_capture #(
  parameter int addr_bits  = 6,
  parameter int skip_bytes = 0,
  parameter int len_bits   = 11,
  parameter int one_shot   = 0
) (
  input  logic                       clk,
  input  logic                       resn,
  input  logic                       rx_crs_dv,
  input  logic [1:0]                 rx_d,
  input  logic                       arm,
  output logic                       byte_valid,
  output logic [7:0]                 byte_data,
  output logic                       frame_done,
  output logic [len_bits-1:0]        frame_len,
  output logic                       crc_ok,
  output logic                       overflow,
  output logic                       armed,
  output logic [(8<<addr_bits)-1:0]  capture
);

  typedef enum logic [1:0] {
    HUNT,
    PRE,
    DATA,
    DRAIN
  } state_t;

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] SKIP    = 32'(skip_bytes);
  localparam logic [31:0] WEND    =
    32'(skip_bytes + (1 << addr_bits));

  state_t state;
  state_t state_nxt;

  logic sfd_hit;
  logic frame_end;
  logic dibit_en;

  logic [1:0]          phase;
  logic [5:0]          sr;
  logic [len_bits-1:0] cnt;
  logic [31:0]         crc;
  logic                cap_frame;
  logic                ovf_frame;

  logic [7:0]           byte_nxt;
  logic [31:0]          n_idx;
  logic                 in_win;
  logic                 past_win;
  logic [addr_bits-1:0] slot;

  // Two bits per cycle, rx_d[0] is the earlier bit on the wire.
  function automatic logic [31:0] crc2(
    input logic [31:0] c,
    input logic [1:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i])
        r = (r >> 1) ^ POLY;
      else
        r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge resn) begin
    if (!resn)
      state <= HUNT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sfd_hit   = 1'b0;
    frame_end = 1'b0;
    dibit_en  = 1'b0;
    unique case (state)
      HUNT: begin
        if (rx_crs_dv && rx_d == 2'b01)
          state_nxt = PRE;
      end
      PRE: begin
        if (!rx_crs_dv) begin
          state_nxt = HUNT;
        end else if (rx_d == 2'b11) begin
          state_nxt = DATA;
          sfd_hit   = 1'b1;
        end else if (rx_d != 2'b01) begin
          state_nxt = DRAIN;
        end
      end
      DATA: begin
        if (!rx_crs_dv) begin
          state_nxt = HUNT;
          frame_end = 1'b1;
        end else begin
          dibit_en = 1'b1;
        end
      end
      DRAIN: begin
        if (!rx_crs_dv)
          state_nxt = HUNT;
      end
    endcase
  end

  assign byte_nxt = {rx_d, sr};
  assign n_idx    = 32'(cnt);
  assign in_win   = (n_idx >= SKIP) && (n_idx < WEND);
  assign past_win = (n_idx >= WEND);
  assign slot     =
    n_idx[addr_bits-1:0] - SKIP[addr_bits-1:0];

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      crc_ok     <= 1'b0;
      overflow   <= 1'b0;
      armed      <= 1'b1;
      capture    <= '0;
      phase      <= '0;
      sr         <= '0;
      cnt        <= '0;
      crc        <= '1;
      cap_frame  <= 1'b0;
      ovf_frame  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_done <= frame_end;

      if (sfd_hit) begin
        phase     <= '0;
        cnt       <= '0;
        crc       <= '1;
        cap_frame <= armed;
        ovf_frame <= 1'b0;
        if (armed)
          capture <= '0;
      end

      if (dibit_en) begin
        phase <= phase + 2'd1;
        sr    <= {rx_d, sr[5:2]};
        crc   <= crc2(crc, rx_d);
        if (phase == 2'd3) begin
          byte_valid <= 1'b1;
          byte_data  <= byte_nxt;
          if (cnt != '1)
            cnt <= cnt + 1'b1;
          if (cap_frame && in_win)
            capture[{slot, 3'b000} +: 8] <= byte_nxt;
          if (past_win)
            ovf_frame <= 1'b1;
        end
      end

      // A trailing partial byte (phase != 0) fails the frame.
      if (frame_end && cap_frame) begin
        frame_len <= cnt;
        crc_ok    <= (crc == RESIDUE) && (phase == 2'd0);
        overflow  <= ovf_frame;
      end

      // arm beats a simultaneous one-shot clear.
      if (arm)
        armed <= 1'b1;
      else if (frame_end && cap_frame && one_shot != 0)
        armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rmii_rx_capture.sv
// Self-checking bench for rmii_rx_capture: three instances (default,
// skip_bytes=14, one_shot=1) fed the same RMII stream, frame-level model.
module tb_rmii_rx_capture;

  localparam int N = 3;
  localparam logic [31:0] POLY = 32'hEDB88320;

  logic       clk = 1'b0;
  logic       resn = 1'b0;
  logic       crs_dv = 1'b0;
  logic [1:0] rx_d = 2'b00;
  logic       arm = 1'b0;

  logic         bv  [N];
  logic [7:0]   bd  [N];
  logic         fd  [N];
  logic [10:0]  fl  [N];
  logic         ck  [N];
  logic         ov  [N];
  logic         ar  [N];
  logic [511:0] cap [N];

  always #10 clk = ~clk;

  rmii_rx_capture #(
    .addr_bits(6), .skip_bytes(0), .len_bits(11), .one_shot(0)
  ) d0 (
    .clk(clk), .resn(resn), .rx_crs_dv(crs_dv), .rx_d(rx_d),
    .arm(arm), .byte_valid(bv[0]), .byte_data(bd[0]),
    .frame_done(fd[0]), .frame_len(fl[0]), .crc_ok(ck[0]),
    .overflow(ov[0]), .armed(ar[0]), .capture(cap[0])
  );

  rmii_rx_capture #(
    .addr_bits(6), .skip_bytes(14), .len_bits(11), .one_shot(0)
  ) d1 (
    .clk(clk), .resn(resn), .rx_crs_dv(crs_dv), .rx_d(rx_d),
    .arm(arm), .byte_valid(bv[1]), .byte_data(bd[1]),
    .frame_done(fd[1]), .frame_len(fl[1]), .crc_ok(ck[1]),
    .overflow(ov[1]), .armed(ar[1]), .capture(cap[1])
  );

  rmii_rx_capture #(
    .addr_bits(6), .skip_bytes(0), .len_bits(11), .one_shot(1)
  ) d2 (
    .clk(clk), .resn(resn), .rx_crs_dv(crs_dv), .rx_d(rx_d),
    .arm(arm), .byte_valid(bv[2]), .byte_data(bd[2]),
    .frame_done(fd[2]), .frame_len(fl[2]), .crc_ok(ck[2]),
    .overflow(ov[2]), .armed(ar[2]), .capture(cap[2])
  );

  int tests = 0;
  int fails = 0;

  int           skip_m [N] = '{0, 14, 0};
  bit           os_m   [N] = '{1'b0, 1'b0, 1'b1};
  bit           arm_m  [N];
  logic [10:0]  len_m  [N];
  logic         crc_m  [N];
  logic         ovf_m  [N];
  logic [511:0] cap_m  [N];

  logic [7:0] fr  [$];
  logic [7:0] rxq [$];
  int fd0_cnt = 0;
  bit prev_bv = 1'b0;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bv[0]) begin
      rxq.push_back(bd[0]);
      chk("bv_not_back_to_back", 512'(prev_bv), 512'(0));
    end
    if (fd[0])
      fd0_cnt++;
    prev_bv = bv[0];
  end

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) begin
      c ^= 32'(fr[i]);
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_good();
    int n;
    n = fr.size();
    if (n < 4)
      return 1'b0;
    return {fr[n-1], fr[n-2], fr[n-3], fr[n-4]} == crc_of(n - 4);
  endfunction

  task automatic make_frame(input int ndata, input int flip);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < ndata; i++)
      fr.push_back(8'($urandom));
    c = crc_of(ndata);
    for (int i = 0; i < 4; i++)
      fr.push_back(c[8*i +: 8]);
    if (flip >= 0)
      fr[flip] = fr[flip] ^ (8'd1 << $urandom_range(7, 0));
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      arm_m[k] = 1'b1;
      len_m[k] = '0;
      crc_m[k] = 1'b0;
      ovf_m[k] = 1'b0;
      cap_m[k] = '0;
    end
  endtask

  task automatic apply_model(input int partial, input bit arm_mid);
    bit good;
    bit captured;
    int n;
    good = fcs_good() && partial == 0;
    n = fr.size();
    for (int k = 0; k < N; k++) begin
      captured = arm_m[k];
      if (arm_mid)
        arm_m[k] = 1'b1;
      if (captured) begin
        len_m[k] = 11'(n);
        crc_m[k] = good;
        ovf_m[k] = n > skip_m[k] + 64;
        cap_m[k] = '0;
        for (int i = 0; i < 64; i++)
          if (skip_m[k] + i < n)
            cap_m[k][8*i +: 8] = fr[skip_m[k] + i];
        if (os_m[k])
          arm_m[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s d%0d frame_len", tag, k), 512'(fl[k]),
          512'(len_m[k]));
      chk($sformatf("%s d%0d crc_ok", tag, k), 512'(ck[k]),
          512'(crc_m[k]));
      chk($sformatf("%s d%0d overflow", tag, k), 512'(ov[k]),
          512'(ovf_m[k]));
      chk($sformatf("%s d%0d armed", tag, k), 512'(ar[k]),
          512'(arm_m[k]));
      chk($sformatf("%s d%0d capture", tag, k), cap[k], cap_m[k]);
    end
  endtask

  task automatic drive(input logic dv, input logic [1:0] d);
    @(negedge clk);
    crs_dv = dv;
    rx_d   = d;
    arm    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00);
  endtask

  task automatic preamble();
    repeat (31) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int j = 0; j < 4; j++)
      drive(1'b1, b[2*j +: 2]);
  endtask

  task automatic send_frame(input string tag, input int partial,
                            input int arm_byte);
    int f0;
    logic [7:0] b;
    bit same;
    rxq.delete();
    f0 = fd0_cnt;
    preamble();
    for (int i = 0; i < fr.size(); i++) begin
      b = fr[i];
      for (int j = 0; j < 4; j++) begin
        drive(1'b1, b[2*j +: 2]);
        if (i == arm_byte && j == 0)
          arm = 1'b1;
      end
    end
    for (int j = 0; j < partial; j++)
      drive(1'b1, 2'($urandom));
    drive(1'b0, 2'b00);
    @(negedge clk);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s d%0d frame_done", tag, k), 512'(fd[k]),
          512'(1));
    apply_model(partial, arm_byte >= 0);
    check_all(tag);
    @(negedge clk);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s d%0d frame_done_low", tag, k),
          512'(fd[k]), 512'(0));
    idle(3);
    chk($sformatf("%s done_count", tag), 512'(fd0_cnt - f0),
        512'(1));
    same = rxq.size() == fr.size();
    if (same)
      for (int i = 0; i < fr.size(); i++)
        if (rxq[i] !== fr[i])
          same = 1'b0;
    chk($sformatf("%s byte_stream size=%0d want=%0d", tag,
        rxq.size(), fr.size()), 512'(same), 512'(1));
  endtask

  task automatic pulse_arm();
    drive(1'b0, 2'b00);
    arm = 1'b1;
    drive(1'b0, 2'b00);
    for (int k = 0; k < N; k++)
      arm_m[k] = 1'b1;
    check_all("arm");
  endtask

  initial begin
    int f0;
    logic [7:0] f1_first;

    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst d%0d byte_valid", k), 512'(bv[k]), 512'(0));
      chk($sformatf("rst d%0d byte_data", k), 512'(bd[k]), 512'(0));
      chk($sformatf("rst d%0d frame_done", k), 512'(fd[k]), 512'(0));
    end
    check_all("rst");
    resn = 1'b1;
    idle(4);

    make_frame(60, -1);
    f1_first = fr[0];
    send_frame("good64", 0, -1);
    chk("good64 cap0", 512'(cap[0][7:0]), 512'(f1_first));

    fr[20] = fr[20] ^ 8'h10;
    send_frame("flip20", 0, -1);

    make_frame(96, -1);
    send_frame("ovf100", 0, -1);

    pulse_arm();

    make_frame($urandom_range(20, 90), -1);
    send_frame("rearm", 0, -1);

    make_frame(30, -1);
    send_frame("arm_mid", 0, 10);

    make_frame(30, -1);
    send_frame("partial3", 3, -1);

    fr.delete();
    send_frame("empty", 0, -1);

    rxq.delete();
    f0 = fd0_cnt;
    repeat (31) drive(1'b1, 2'b01);
    drive(1'b1, 2'b00);
    send_byte(8'hD5);
    repeat (5) send_byte(8'($urandom));
    idle(4);
    chk("badsfd done_count", 512'(fd0_cnt - f0), 512'(0));
    chk("badsfd bytes", 512'(rxq.size()), 512'(0));
    check_all("badsfd");

    for (int r = 0; r < 5; r++) begin
      if ($urandom_range(0, 1) == 1)
        pulse_arm();
      make_frame($urandom_range(0, 110),
                 $urandom_range(0, 1) == 1 ? 2 : -1);
      send_frame($sformatf("rnd%0d", r), $urandom_range(0, 3), -1);
    end

    make_frame(40, -1);
    preamble();
    for (int i = 0; i < 10; i++)
      send_byte(fr[i]);
    #2 resn = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("midrst d%0d byte_valid", k), 512'(bv[k]),
          512'(0));
      chk($sformatf("midrst d%0d byte_data", k), 512'(bd[k]),
          512'(0));
      chk($sformatf("midrst d%0d frame_done", k), 512'(fd[k]),
          512'(0));
    end
    check_all("midrst");
    drive(1'b1, 2'b10);
    resn = 1'b1;
    rxq.delete();
    f0 = fd0_cnt;
    repeat (47) drive(1'b1, 2'b10);
    idle(4);
    chk("tail done_count", 512'(fd0_cnt - f0), 512'(0));
    chk("tail bytes", 512'(rxq.size()), 512'(0));
    check_all("tail");

    make_frame(50, -1);
    send_frame("recover", 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rmii_rx_capture.md
# rmii_rx_capture

Parametrised RMII receive front end and frame capture buffer, clocked by the 50 MHz PHY reference clock. It hunts the preamble and SFD, assembles dibits into bytes and streams them out. It also checks the Ethernet FCS, reports frame length and status, and stores a configurable window of each frame in a flat register array that the hex display decoders consume directly. It adds byte assembly, strict SFD checking, CRC32 checking, overflow reporting and one-shot/re-arm capture.

## Interface
- `addr_bits`, 6: capture depth is 2**addr_bits bytes.
- `skip_bytes`, 0: number of leading frame bytes (after SFD) that are not stored.
- `len_bits`, 11: width of `frame_len`.
- `one_shot`, 0: 1 means the buffer freezes after one captured frame until `arm`.

- `clk`  in  1: RMII 50 MHz reference clock. This is the only clock.
- `resn`  in  1: asynchronous, active-low reset.
- `rx_crs_dv`  in  1: RMII CRS_DV.
- `rx_d`  in  2: RMII RXD[1:0].
- `arm`  in  1: single-cycle pulse that re-enables capture.
- `byte_valid`  out  1: single-cycle strobe, `byte_data` valid.
- `byte_data`  out  8: assembled byte, LSB dibit first.
- `frame_done`  out  1: single-cycle pulse at end of frame.
- `frame_len`  out  len_bits: byte count of the last captured frame, including FCS.
- `crc_ok`  out  1: the last captured frame had a good FCS and no dribble.
- `overflow`  out  1: the last captured frame had bytes beyond the buffer window.
- `armed`  out  1: capture is currently enabled.
- `capture`  out  8<<addr_bits: byte i of the window is at [8i+7:8i].

## Operation
- States: HUNT, PRE, DATA, DRAIN.
- HUNT: if `rx_crs_dv`=1 and `rx_d`=01, go to PRE.
- PRE: `rx_d`=01 stays in PRE. `rx_d`=11 is the SFD; go to DATA, clear the dibit phase, byte counter and CRC. Any other dibit goes to DRAIN.
- PRE or DATA with `rx_crs_dv`=0: go to HUNT. From DATA this ends the frame.
- DRAIN: wait for `rx_crs_dv`=0, then go to HUNT. No `frame_done` is generated.
- DATA: shift in each dibit as sr <= {rx_d, sr[7:2]}. Each fourth dibit completes a byte, increments the byte counter and strobes `byte_valid`.
- CRC32:
  - reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF;
  - updated 2 bits per DATA cycle over all bytes, including skipped bytes and the FCS;
  - the frame is good when the register equals 0xDEBB20E3 at end of frame.
- Capture, for a frame whose SFD arrives while `armed`=1:
  - all `capture` bytes clear to 0 at the SFD;
  - byte index n is written to slot n−skip_bytes when skip_bytes ≤ n < skip_bytes+2**addr_bits;
  - any byte with n ≥ skip_bytes+2**addr_bits sets that frame's overflow.
- End of a captured frame:
  - `frame_len` is set to the byte count, saturating at 2**len_bits−1;
  - `crc_ok` is set to (CRC match AND dibit phase=0);
  - `overflow` is updated;
  - if `one_shot`=1, `armed` is cleared.
- Uncaptured frames (`armed`=0 at the SFD) still stream `byte_valid`/`byte_data` and pulse `frame_done`. `capture`, `frame_len`, `crc_ok` and `overflow` are left unchanged.
- `arm` sets `armed`. If `arm` arrives in the same cycle as a one-shot clear, set wins. `arm` during a frame does not retroactively capture that frame.
- Supported speed is 100 Mbit/s only; CRS_DV end-of-frame toggling is not filtered.

## Timing
- Reset state: all outputs 0, `capture` all 0, state HUNT, `armed`=1.
- `byte_valid` is high the cycle after the 4th dibit of a byte is sampled. It never asserts in two consecutive cycles.
- The `capture` slot updates in the same cycle `byte_valid` is high.
- `frame_done` is high the cycle after the first `rx_crs_dv`=0 sample in DATA.
- `frame_len`, `crc_ok` and `overflow` are valid in the `frame_done` cycle and hold until the next captured frame ends.
- A frame ending in a partial byte:
  - the partial byte is discarded and no `byte_valid` is issued;
  - `crc_ok`=0;
  - `frame_len` counts only whole bytes.
- A frame with SFD then immediate CRS drop gives `frame_done` with `frame_len`=0 and `crc_ok`=0.
- `resn` asserted mid-frame: everything returns to reset values at once. After release, the rest of that frame is ignored: the block stays in HUNT until a fresh 01…11 sequence.

## Test plan
- Valid 64-byte frame (60 data bytes + correct FCS), defaults → 64 `byte_valid` strobes; `frame_done` with `frame_len`=64, `crc_ok`=1, `overflow`=0; `capture[7:0]` equals the first destination byte.
- Same frame with byte 20 bit-flipped → `crc_ok`=0, `frame_len`=64.
- `skip_bytes`=14, 64-byte frame → `capture[7:0]` equals frame byte 14; slots 50..63 hold bytes 64+ or are 0 (frame shorter, so 0).
- 100-byte good frame, depth 64 → `overflow`=1, `crc_ok`=1, `frame_len`=100, slot 63 equals byte 63.
- `one_shot`=1: frame A then frame B → `capture` holds A, `armed`=0; pulse `arm`, send B → `capture` holds B.
- Bad SFD (01×31 then 00), then frame ending after 3 dibits of a byte, then `resn` pulse mid-frame → no `frame_done` for the first; second gives `crc_ok`=0; all outputs are 0 after reset and the remainder of the interrupted frame is ignored.
